// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
package ifid_pkg;

    localparam int unsigned IFID_DEPTH_DEF = 4;
    localparam int unsigned WORD_W         = 16;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
        logic              err;
    } ifid_entry_t;

    typedef enum logic [1:0] {
        Q_IDLE,
        Q_PUSH,
        Q_POP,
        Q_BOTH
    } q_op_e;

endpackage

// File: rtl/ifid_queue.sv
// IF/ID instruction queue: first-word-fall-through FIFO with a registered head entry
// and branch flush.
module ifid_queue
    import ifid_pkg::*;
#(
    parameter int unsigned DEPTH = IFID_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_vld_ifid_p1,
    input  logic [WORD_W-1:0]          pc_p1,
    input  logic [WORD_W-1:0]          inst_ifid_p1,
    input  logic                       err_p1,
    output logic                       ifid_rdy_ifif_p1,
    input  logic                       branch_taken_ixif_p1,
    input  logic                       id_rdy_p1,
    output logic                       id_vld_p1,
    output logic [WORD_W-1:0]          id_pc_p1,
    output logic [WORD_W-1:0]          id_inst_p1,
    output logic                       id_err_p1,
    output logic [$clog2(DEPTH):0]     ifid_cnt_p1
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    ifid_entry_t       mem [DEPTH];
    ifid_entry_t       in_ent;
    ifid_entry_t       head;
    ifid_entry_t       head_nxt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              push;
    logic              pop;
    logic              flush;
    q_op_e             op;

    assign in_ent = '{pc: pc_p1, inst: inst_ifid_p1, err: err_p1};

    assign flush            = branch_taken_ixif_p1;
    assign ifid_rdy_ifif_p1 = (cnt < FULL_CNT);
    assign id_vld_p1        = (cnt != '0);
    assign push             = fetch_vld_ifid_p1 && ifid_rdy_ifif_p1 && !flush;
    assign pop              = id_vld_p1 && id_rdy_p1 && !flush;

    always_comb begin
        op = Q_IDLE;
        case ({pop, push})
            2'b01:   op = Q_PUSH;
            2'b10:   op = Q_POP;
            2'b11:   op = Q_BOTH;
            default: op = Q_IDLE;
        endcase

        cnt_nxt    = cnt;
        rd_ptr_nxt = rd_ptr;
        unique case (op)
            Q_PUSH: cnt_nxt = cnt + CW'(1);
            Q_POP: begin
                cnt_nxt    = cnt - CW'(1);
                rd_ptr_nxt = rd_ptr + PW'(1);
            end
            Q_BOTH: rd_ptr_nxt = rd_ptr + PW'(1);
            default: ;
        endcase

        // The head register is reloaded with whatever entry will sit at the read
        // pointer after this edge; if that slot is the one being written now, the
        // incoming word is forwarded since the array has not captured it yet.
        head_nxt = head;
        if (cnt_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr))
                head_nxt = in_ent;
            else
                head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_ent;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else if (flush) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            cnt    <= cnt_nxt;
            rd_ptr <= rd_ptr_nxt;
            head   <= head_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
        end
    end

    assign id_pc_p1    = head.pc;
    assign id_inst_p1  = head.inst;
    assign id_err_p1   = head.err;
    assign ifid_cnt_p1 = cnt;

    a_cnt_bound: assert property (@(posedge clk) cnt <= FULL_CNT);

endmodule

// File: tb/tb_ifid_queue.sv
// Randomized scoreboard bench for ifid_queue against a queue-based reference model.
module tb_ifid_queue;
    import ifid_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   fetch_vld_ifid_p1;
    logic [15:0]            pc_p1;
    logic [15:0]            inst_ifid_p1;
    logic                   err_p1;
    logic                   ifid_rdy_ifif_p1;
    logic                   branch_taken_ixif_p1;
    logic                   id_rdy_p1;
    logic                   id_vld_p1;
    logic [15:0]            id_pc_p1;
    logic [15:0]            id_inst_p1;
    logic                   id_err_p1;
    logic [$clog2(DEPTH):0] ifid_cnt_p1;

    ifid_queue #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_vld_ifid_p1    (fetch_vld_ifid_p1),
        .pc_p1                (pc_p1),
        .inst_ifid_p1         (inst_ifid_p1),
        .err_p1               (err_p1),
        .ifid_rdy_ifif_p1     (ifid_rdy_ifif_p1),
        .branch_taken_ixif_p1 (branch_taken_ixif_p1),
        .id_rdy_p1            (id_rdy_p1),
        .id_vld_p1            (id_vld_p1),
        .id_pc_p1             (id_pc_p1),
        .id_inst_p1           (id_inst_p1),
        .id_err_p1            (id_err_p1),
        .ifid_cnt_p1          (ifid_cnt_p1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        bit          rdy;
        bit          vld;
        ifid_entry_t ent;
    } exp_t;

    ifid_entry_t model_q[$];
    ifid_entry_t shown;
    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] next_pc;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model across the coming edge,
    // and queue the outputs expected just after that edge.
    task automatic step(input bit r, input bit f, input logic [15:0] pc,
                        input logic [15:0] inst, input bit e, input bit b, input bit d);
        bit   do_push;
        bit   do_pop;
        exp_t x;
        rst                  = r;
        fetch_vld_ifid_p1    = f;
        pc_p1                = pc;
        inst_ifid_p1         = inst;
        err_p1               = e;
        branch_taken_ixif_p1 = b;
        id_rdy_p1            = d;
        if (!r) begin
            model_q.delete();
            shown = '0;
        end else if (b) begin
            model_q.delete();
        end else begin
            do_push = f && (model_q.size() < DEPTH);
            do_pop  = d && (model_q.size() != 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: pc, inst: inst, err: e});
        end
        if (model_q.size() != 0) shown = model_q[0];
        x.cnt = model_q.size();
        x.rdy = (model_q.size() < DEPTH);
        x.vld = (model_q.size() != 0);
        x.ent = shown;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic fetch(input bit d);
        step(1'b1, 1'b1, next_pc, next_pc ^ 16'h5A00, 1'b0, 1'b0, d);
        next_pc = next_pc + 16'd2;
    endtask

    task automatic idle;
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare each queued expectation with the DUT just after its edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("cnt",  int'(ifid_cnt_p1),      x.cnt);
                chk("rdy",  int'(ifid_rdy_ifif_p1), int'(x.rdy));
                chk("vld",  int'(id_vld_p1),        int'(x.vld));
                chk("pc",   int'(id_pc_p1),         int'(x.ent.pc));
                chk("inst", int'(id_inst_p1),       int'(x.ent.inst));
                chk("err",  int'(id_err_p1),        int'(x.ent.err));
            end
        end
    end

    initial begin
        shown = '0;
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Three pushes with decode stalled, then fill and overfill.
        next_pc = 16'h0000;
        repeat (3) fetch(1'b0);
        fetch(1'b0);
        fetch(1'b0);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle();

        // Two queued, then concurrent push/pop long enough to wrap the pointers twice.
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        next_pc = 16'h0100;
        repeat (2) fetch(1'b0);
        repeat (10) fetch(1'b1);
        idle();

        // Flush with push and pop active, then a fresh push.
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        next_pc = 16'h0200;
        repeat (3) fetch(1'b0);
        step(1'b1, 1'b1, 16'h0300, 16'h1111, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 16'h0040, 16'h2222, 1'b0, 1'b0, 1'b0);
        idle();

        // Error-flagged word passes unchanged.
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h0042, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle();

        // Reset with a partly full queue and a push in flight.
        next_pc = 16'h0400;
        repeat (3) fetch(1'b0);
        step(1'b0, 1'b1, 16'h0500, 16'h3333, 1'b0, 1'b0, 1'b1);
        idle();

        repeat (2000) begin
            step(($urandom_range(63) != 0), ($urandom_range(3) != 0),
                 16'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom_range(15) == 0), 1'($urandom));
        end
        idle();

        begin
            int budget = 20;
            while (sb.size() != 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            tests++;
            if (sb.size() != 0) begin
                fails++;
                $display("FAIL drain: got %0d pending expected 0", sb.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
